// File: rtl/mem_pkg.sv
// Shared types, constants and helpers for the memory-stage controller.
package mem_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

    localparam logic [3:0] BE_WORD = 4'hF;
    localparam logic       RW_NONE = 1'b1;

    // Byte index of the lowest enabled lane; an empty mask behaves like lane 0.
    function automatic logic [1:0] lane_offset(input logic [3:0] byte_en);
        logic [1:0] off_s;
        casez (byte_en)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        return off_s;
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational byte-lane steering: shifts store data up to its lanes and
// extracts load data down to bit 0 with zero extension.
module byte_lane_align
    import mem_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic [3:0]      byte_en,
    input  logic [BITS-1:0] store_data,
    input  logic [BITS-1:0] load_data,
    output logic [BITS-1:0] store_aligned,
    output logic [BITS-1:0] load_aligned
);

    logic [4:0]      shamt_s;
    logic [BITS-1:0] lane_mask_s;

    assign shamt_s = {lane_offset(byte_en), 3'b000};

    // Expand the four lane enables into a bit mask over the data word.
    always_comb begin
        lane_mask_s = '0;
        for (int i = 0; i < 4; i++) begin
            lane_mask_s[8*i +: 8] = {8{byte_en[i]}};
        end
    end

    assign store_aligned = store_data << shamt_s;
    assign load_aligned  = (load_data & lane_mask_s) >> shamt_s;

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: data-memory req/ack handshake, LL/SC link
// tracking, pipeline stall and the MEM/WB register.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int REG_WORDS = 32,
    parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic [BITS-1:0]    alu_out_s4,
    input  logic [BITS-1:0]    r2_data_s4,
    input  logic [3:0]         byte_en_s4,
    input  logic               sel_mem_s4,
    input  logic               mem_rw_s4,
    input  logic               rw_s4,
    input  logic [ADDR_LEFT:0] waddr_s4,
    input  logic               load_link_s4,
    input  logic               check_link_s4,
    input  logic               atomic_s4,
    input  logic               halt_s4,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               dmem_lock,
    output logic [BITS-1:0]    dmem_addr,
    output logic [3:0]         dmem_be,
    output logic [BITS-1:0]    dmem_wdata,
    input  logic               dmem_ack,
    input  logic [BITS-1:0]    dmem_rdata,
    output logic               stall_mem,
    output logic [BITS-1:0]    wb_data_s5,
    output logic [ADDR_LEFT:0] waddr_s5,
    output logic               rw_s5,
    output logic               halt_s5
);

    mem_state_t       state_r;
    logic             link_valid_r;
    logic [BITS-3:0]  link_addr_r;
    logic             link_hit_s;
    logic             is_sc_s;
    logic             sc_fail_s;
    logic             mem_op_s;
    logic             ack_s;
    logic [BITS-1:0]  load_aligned_s;
    logic [BITS-1:0]  wb_data_s;

    assign link_hit_s = link_valid_r && (link_addr_r == alu_out_s4[BITS-1:2]);
    assign is_sc_s    = check_link_s4 & ~mem_rw_s4;
    assign sc_fail_s  = is_sc_s & ~link_hit_s;
    assign mem_op_s   = sel_mem_s4 & ~sc_fail_s;
    assign ack_s      = (state_r == REQ) & dmem_ack;
    assign stall_mem  = mem_op_s & ~ack_s;

    assign dmem_req  = (state_r == REQ);
    assign dmem_we   = ~mem_rw_s4 & dmem_req;
    assign dmem_lock = atomic_s4 & dmem_req;
    assign dmem_addr = {alu_out_s4[BITS-1:2], 2'b00};
    assign dmem_be   = byte_en_s4;

    byte_lane_align #(.BITS(BITS)) u_align (
        .byte_en       (byte_en_s4),
        .store_data    (r2_data_s4),
        .load_data     (dmem_rdata),
        .store_aligned (dmem_wdata),
        .load_aligned  (load_aligned_s)
    );

    // Select the write-back value: load data, SC status flag, or ALU result.
    always_comb begin
        if (sel_mem_s4 & mem_rw_s4) begin
            wb_data_s = load_aligned_s;
        end else if (is_sc_s) begin
            wb_data_s = {{(BITS-1){1'b0}}, ~sc_fail_s};
        end else begin
            wb_data_s = alu_out_s4;
        end
    end

    // Access FSM; inputs are held by the stall while REQ waits for ack.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE:    state_r <= mem_op_s ? REQ : IDLE;
                REQ:     state_r <= dmem_ack ? IDLE : REQ;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Link register: LL ack arms it; any SC completion or a store hit disarms it.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            link_valid_r <= 1'b0;
            link_addr_r  <= '0;
        end else if (ack_s & mem_rw_s4 & ~load_link_s4) begin
            link_valid_r <= 1'b1;
            link_addr_r  <= alu_out_s4[BITS-1:2];
        end else if (sc_fail_s | (ack_s & ~mem_rw_s4 & (is_sc_s | link_hit_s))) begin
            link_valid_r <= 1'b0;
        end else begin
            link_valid_r <= link_valid_r;
        end
    end

    // MEM/WB register; a stall inserts a bubble while keeping data and address.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wb_data_s5 <= '0;
            waddr_s5   <= '0;
            rw_s5      <= RW_NONE;
            halt_s5    <= 1'b0;
        end else if (!stall_mem) begin
            wb_data_s5 <= wb_data_s;
            waddr_s5   <= waddr_s4;
            rw_s5      <= rw_s4;
            halt_s5    <= halt_s4;
        end else begin
            rw_s5      <= RW_NONE;
            halt_s5    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected write-backs are queued when
// an instruction is driven and compared when it retires into s5.
module tb_mem_access_unit;
    import mem_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        halt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_;
    logic [31:0] alu_out_s4, r2_data_s4, dmem_rdata;
    logic [3:0]  byte_en_s4;
    logic        sel_mem_s4, mem_rw_s4, rw_s4, load_link_s4, check_link_s4;
    logic        atomic_s4, halt_s4, dmem_ack;
    logic [4:0]  waddr_s4;
    logic        dmem_req, dmem_we, dmem_lock, stall_mem, rw_s5, halt_s5;
    logic [31:0] dmem_addr, dmem_wdata, wb_data_s5;
    logic [3:0]  dmem_be;
    logic [4:0]  waddr_s5;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          pend_kind = 0;
    int          stalls, reqs;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we, seen_lock;

    mem_access_unit dut (
        .clk(clk), .rst_(rst_),
        .alu_out_s4(alu_out_s4), .r2_data_s4(r2_data_s4), .byte_en_s4(byte_en_s4),
        .sel_mem_s4(sel_mem_s4), .mem_rw_s4(mem_rw_s4), .rw_s4(rw_s4),
        .waddr_s4(waddr_s4), .load_link_s4(load_link_s4), .check_link_s4(check_link_s4),
        .atomic_s4(atomic_s4), .halt_s4(halt_s4),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_lock(dmem_lock),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
        .wb_data_s5(wb_data_s5), .waddr_s5(waddr_s5), .rw_s5(rw_s5), .halt_s5(halt_s5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic set_idle();
        sel_mem_s4 = 1'b0; mem_rw_s4 = 1'b1; rw_s4 = 1'b1; waddr_s4 = 5'd0;
        load_link_s4 = 1'b1; check_link_s4 = 1'b0; atomic_s4 = 1'b0; halt_s4 = 1'b0;
        alu_out_s4 = 32'h0; r2_data_s4 = 32'h0; byte_en_s4 = BE_WORD;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
    endtask

    // Drives one s4 instruction and services its memory access; called at posedge+1.
    task automatic run_op(input logic sel, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic ll_n,
                          input logic sc, input logic [4:0] wa, input logic rwn,
                          input int ack_delay, input logic [31:0] rdata,
                          output int n_stall, output int n_req);
        int req_seen;
        bit done;
        sel_mem_s4 = sel; mem_rw_s4 = rd; alu_out_s4 = addr; r2_data_s4 = wdata;
        byte_en_s4 = be; load_link_s4 = ll_n; check_link_s4 = sc; waddr_s4 = wa; rw_s4 = rwn;
        n_stall = 0; n_req = 0; req_seen = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            dmem_ack   = dmem_req && (req_seen == ack_delay);
            dmem_rdata = dmem_ack ? rdata : 32'h0;
            @(negedge clk);
            if (stall_mem) n_stall++;
            if (dmem_req) begin
                n_req++; req_seen++;
                seen_addr = dmem_addr; seen_wdata = dmem_wdata; seen_be = dmem_be;
                seen_we = dmem_we; seen_lock = dmem_lock;
            end
            done = !stall_mem;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        set_idle();
    endtask

    // Classify each cycle mid-way: retiring op, bubble/no-write, or reset.
    always @(negedge clk) begin
        if (!rst_) pend_kind = 0;
        else if (stall_mem || rw_s4) pend_kind = 2;
        else pend_kind = 1;
    end

    // Compare s5 just after the edge against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (pend_kind == 1) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_data", wb_data_s5, e.data);
                check("waddr", {27'd0, waddr_s5}, {27'd0, e.addr});
                check("rw_s5", {31'd0, rw_s5}, 32'd0);
                check("halt_s5", {31'd0, halt_s5}, {31'd0, e.halt});
            end
        end else if (pend_kind == 2) begin
            check("bubble_rw", {31'd0, rw_s5}, 32'd1);
        end
    end

    initial begin
        rst_ = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        check("rst_lock", {31'd0, dmem_lock}, 32'd0);
        check("rst_stall", {31'd0, stall_mem}, 32'd0);
        check("rst_rw_s5", {31'd0, rw_s5}, 32'd1);
        check("rst_halt_s5", {31'd0, halt_s5}, 32'd0);
        check("rst_wb", wb_data_s5, 32'd0);
        check("rst_waddr", {27'd0, waddr_s5}, 32'd0);
        @(negedge clk); #2 rst_ = 1'b1;
        @(posedge clk); #1;

        // Word load, ack three cycles after request
        exp_q.push_back('{32'hDEADBEEF, 5'd5, 1'b0});
        run_op(1, 1, 32'h100, 0, 4'b1111, 1, 0, 5'd5, 0, 3, 32'hDEADBEEF, stalls, reqs);
        check("lw_stall_cycles", stalls, 32'd4);
        check("lw_req_cycles", reqs, 32'd4);
        check("lw_addr", seen_addr, 32'h100);
        check("lw_we", {31'd0, seen_we}, 32'd0);

        // Byte load from lane 2 of an unaligned address
        exp_q.push_back('{32'h00000022, 5'd6, 1'b0});
        run_op(1, 1, 32'h102, 0, 4'b0100, 1, 0, 5'd6, 0, 1, 32'h11223344, stalls, reqs);
        check("lb_addr", seen_addr, 32'h100);
        check("lb_stall_cycles", stalls, 32'd2);

        // Empty lane mask loads zero
        exp_q.push_back('{32'h0, 5'd4, 1'b0});
        run_op(1, 1, 32'h104, 0, 4'b0000, 1, 0, 5'd4, 0, 0, 32'hFFFFFFFF, stalls, reqs);

        // Locked half-word store to upper lanes
        atomic_s4 = 1'b1;
        run_op(1, 0, 32'h42, 32'h0000ABCD, 4'b1100, 1, 0, 5'd0, 1, 0, 0, stalls, reqs);
        check("sh_wdata", seen_wdata, 32'hABCD0000);
        check("sh_be", {28'd0, seen_be}, 32'hC);
        check("sh_we", {31'd0, seen_we}, 32'd1);
        check("sh_lock", {31'd0, seen_lock}, 32'd1);
        check("sh_req_cycles", reqs, 32'd1);

        // Non-memory op with halt marker passes in one cycle
        halt_s4 = 1'b1;
        exp_q.push_back('{32'h00001234, 5'd3, 1'b1});
        run_op(0, 1, 32'h1234, 0, 4'b1111, 1, 0, 5'd3, 0, 0, 0, stalls, reqs);
        check("alu_stall_cycles", stalls, 32'd0);

        // LL then SC to the same word: pass, then a repeat SC fails without request
        exp_q.push_back('{32'h00000055, 5'd7, 1'b0});
        run_op(1, 1, 32'h200, 0, 4'b1111, 0, 0, 5'd7, 0, 0, 32'h55, stalls, reqs);
        exp_q.push_back('{32'h1, 5'd8, 1'b0});
        run_op(1, 0, 32'h200, 32'h99, 4'b1111, 1, 1, 5'd8, 0, 0, 0, stalls, reqs);
        check("sc_pass_req", reqs, 32'd1);
        check("sc_pass_wdata", seen_wdata, 32'h99);
        exp_q.push_back('{32'h0, 5'd8, 1'b0});
        run_op(1, 0, 32'h200, 32'h99, 4'b1111, 1, 1, 5'd8, 0, 0, 0, stalls, reqs);
        check("sc_repeat_req", reqs, 32'd0);
        check("sc_repeat_stall", stalls, 32'd0);

        // Plain store to the linked word breaks the link
        exp_q.push_back('{32'h00000077, 5'd9, 1'b0});
        run_op(1, 1, 32'h300, 0, 4'b1111, 0, 0, 5'd9, 0, 0, 32'h77, stalls, reqs);
        run_op(1, 0, 32'h300, 32'h5, 4'b1111, 1, 0, 5'd0, 1, 0, 0, stalls, reqs);
        exp_q.push_back('{32'h0, 5'd9, 1'b0});
        run_op(1, 0, 32'h300, 32'h6, 4'b1111, 1, 1, 5'd9, 0, 0, 0, stalls, reqs);
        check("sc_broken_req", reqs, 32'd0);

        // Store to a different word leaves the link intact
        exp_q.push_back('{32'h00000088, 5'd10, 1'b0});
        run_op(1, 1, 32'h600, 0, 4'b1111, 0, 0, 5'd10, 0, 0, 32'h88, stalls, reqs);
        run_op(1, 0, 32'h700, 32'h5, 4'b1111, 1, 0, 5'd0, 1, 2, 0, stalls, reqs);
        exp_q.push_back('{32'h1, 5'd10, 1'b0});
        run_op(1, 0, 32'h600, 32'h7, 4'b1111, 1, 1, 5'd10, 0, 0, 0, stalls, reqs);
        check("sc_other_req", reqs, 32'd1);

        // Reset while a request is outstanding abandons it and clears the link
        exp_q.push_back('{32'h000000AA, 5'd11, 1'b0});
        run_op(1, 1, 32'h400, 0, 4'b1111, 0, 0, 5'd11, 0, 0, 32'hAA, stalls, reqs);
        sel_mem_s4 = 1'b1; mem_rw_s4 = 1'b1; alu_out_s4 = 32'h500; waddr_s4 = 5'd12; rw_s4 = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        @(negedge clk); #2 rst_ = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, dmem_req}, 32'd0);
        check("mid_rst_rw_s5", {31'd0, rw_s5}, 32'd1);
        set_idle();
        @(negedge clk); #2 rst_ = 1'b1;
        @(posedge clk); #1 dmem_ack = 1'b1;
        @(negedge clk);
        check("late_ack_req", {31'd0, dmem_req}, 32'd0);
        check("late_ack_stall", {31'd0, stall_mem}, 32'd0);
        @(posedge clk); #1 dmem_ack = 1'b0;
        check("late_ack_rw_s5", {31'd0, rw_s5}, 32'd1);
        exp_q.push_back('{32'h0, 5'd13, 1'b0});
        run_op(1, 0, 32'h400, 32'h1, 4'b1111, 1, 1, 5'd13, 0, 0, 0, stalls, reqs);
        check("sc_after_rst_req", reqs, 32'd0);

        repeat (3) @(posedge clk);
        #2;
        check("sb_drain", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
